// File: rtl/wb_counter_bank_pkg.sv
// wb_counter_bank_pkg: register map, CTRL layout and helpers shared by the counter bank.
package wb_counter_bank_pkg;
    localparam logic [3:0] OFF_CTRL = 4'h0;
    localparam logic [3:0] OFF_LOAD = 4'h4;
    localparam logic [3:0] OFF_CMP = 4'h8;
    localparam logic [3:0] OFF_VALUE = 4'hC;
    localparam logic [7:0] OFF_IRQ_STATUS = 8'hF0;
    localparam logic [7:0] OFF_ID = 8'hF4;
    localparam int CTRL_EN = 0;
    localparam int CTRL_DIR = 1;
    localparam int CTRL_RELOAD = 2;
    localparam int CTRL_IRQ_EN = 3;
    localparam int CTRL_TOG = 4;
    localparam logic [7:0] ID_VERSION = 8'h01;

    typedef struct packed {
        logic tog;
        logic irq_en;
        logic reload;
        logic dir;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] dat,
                                               input logic [3:0] sel);
        for (int i = 0; i < 4; i++) byte_merge[8*i+:8] = sel[i] ? dat[8*i+:8] : old[8*i+:8];
    endfunction
endpackage

// File: rtl/wb_counter_bank_if.sv
// wb_counter_bank_if: Wishbone classic slave port of the counter bank.
interface wb_counter_bank_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave(input wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  output wbs_ack_o, wbs_dat_o);
    modport master(output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                   input wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/wb_counter_channel.sv
// wb_counter_channel: one up/down counter with load, compare, reload and toggle output.
module wb_counter_channel
    import wb_counter_bank_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [3:0]       wr_off,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_sel,
    input  logic             en_ovr,
    input  logic             en_ext,
    output ctrl_t            ctrl,
    output logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] cmp,
    output logic [WIDTH-1:0] value,
    output logic             hit
);
    logic [31:0] old, wm;
    logic        en_eff, match, wr_value;

    always_comb old = wr_off == OFF_LOAD ? 32'(load) :
                      wr_off == OFF_CMP ? 32'(cmp) :
                      wr_off == OFF_VALUE ? 32'(value) : {27'd0, ctrl};

    assign wm = byte_merge(old, wr_data, wr_sel);
    assign en_eff = en_ovr ? en_ext : ctrl.en;
    assign match = value == cmp;
    assign wr_value = wr_en && wr_off == OFF_VALUE;
    // a software VALUE write takes the cycle: no tick and no compare
    assign hit = en_eff && match && !wr_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl <= '0;
            load <= '0;
            cmp <= '0;
            value <= '0;
        end else begin
            if (wr_en && wr_off == OFF_CTRL) begin
                ctrl.en <= wm[CTRL_EN];
                ctrl.dir <= wm[CTRL_DIR];
                ctrl.reload <= wm[CTRL_RELOAD];
                ctrl.irq_en <= wm[CTRL_IRQ_EN];
            end
            if (wr_en && wr_off == OFF_LOAD) load <= wm[WIDTH-1:0];
            if (wr_en && wr_off == OFF_CMP) cmp <= wm[WIDTH-1:0];
            if (wr_value) value <= wm[WIDTH-1:0];
            else if (en_eff) value <= match && ctrl.reload ? load :
                                      ctrl.dir ? value - 1'b1 : value + 1'b1;
            if (hit) ctrl.tog <= ~ctrl.tog;
        end
    end
endmodule

// File: rtl/wb_counter_bank.sv
// wb_counter_bank: Wishbone-mapped bank of counters with IRQ, GPIO toggles and LA override/observe.
module wb_counter_bank
    import wb_counter_bank_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          IO_PADS   = 38,
    parameter int          IO_LSB    = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wb_counter_bank_if.slave   wbs,
    input  logic [127:0]       la_data_in,
    input  logic [127:0]       la_oenb,
    output logic [127:0]       la_data_out,
    input  logic [IO_PADS-1:0] io_in,
    output logic [IO_PADS-1:0] io_out,
    output logic [IO_PADS-1:0] io_oeb,
    output logic [2:0]         irq
);
    localparam logic [31:0] ID = {ID_VERSION, 8'(NUM_CH), 8'(WIDTH), 8'h00};

    ctrl_t             ch_ctrl  [NUM_CH];
    logic [WIDTH-1:0]  ch_load  [NUM_CH];
    logic [WIDTH-1:0]  ch_cmp   [NUM_CH];
    logic [WIDTH-1:0]  ch_value [NUM_CH];
    logic [NUM_CH-1:0] ch_hit, ch_irq_en, ch_tog, status, clr;
    logic [7:0]        off;
    logic [3:0]        ch_idx, reg_off;
    logic [31:0]       rdata;
    logic              req, wr, irq0, unused;

    assign off = wbs.wbs_adr_i[7:0];
    assign ch_idx = off[7:4];
    assign reg_off = {off[3:2], 2'b00};
    assign req = wbs.wbs_cyc_i && wbs.wbs_stb_i && !wbs.wbs_ack_o &&
                 wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8];
    assign wr = req && wbs.wbs_we_i;
    assign clr = wr && off == OFF_IRQ_STATUS && wbs.wbs_sel_i[0] ? wbs.wbs_dat_i[NUM_CH-1:0] : '0;
    assign unused = ^{io_in, la_data_in, la_oenb, wbs.wbs_adr_i[1:0]};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        wb_counter_channel #(.WIDTH(WIDTH)) u_ch (
            .clk(wb_clk_i),
            .rst(wb_rst_i),
            .wr_en(wr && ch_idx == 4'(c)),
            .wr_off(reg_off),
            .wr_data(wbs.wbs_dat_i),
            .wr_sel(wbs.wbs_sel_i),
            .en_ovr(!la_oenb[127-c]),
            .en_ext(la_data_in[127-c]),
            .ctrl(ch_ctrl[c]),
            .load(ch_load[c]),
            .cmp(ch_cmp[c]),
            .value(ch_value[c]),
            .hit(ch_hit[c])
        );
        assign ch_irq_en[c] = ch_ctrl[c].irq_en;
        assign ch_tog[c] = ch_ctrl[c].tog;
    end

    for (genvar c = 0; c < 4; c++) begin : g_la
        if (c < NUM_CH) begin : g_used
            assign la_data_out[32*c+:32] = 32'(ch_value[c]);
        end else begin : g_zero
            assign la_data_out[32*c+:32] = '0;
        end
    end

    always_comb begin
        io_out = '0;
        io_out[IO_LSB+:NUM_CH] = ch_tog;
        io_oeb = '1;
        io_oeb[IO_LSB+:NUM_CH] = '0;
    end

    always_comb begin
        rdata = off == OFF_ID ? ID : off == OFF_IRQ_STATUS ? 32'(status) : '0;
        for (int c = 0; c < NUM_CH; c++)
            if (ch_idx == 4'(c))
                rdata = reg_off == OFF_CTRL ? {27'd0, ch_ctrl[c]} :
                        reg_off == OFF_LOAD ? 32'(ch_load[c]) :
                        reg_off == OFF_CMP ? 32'(ch_cmp[c]) : 32'(ch_value[c]);
    end

    // a match set in the same cycle as a W1C clear wins
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= '0;
            status <= '0;
            irq0 <= 1'b0;
        end else begin
            wbs.wbs_ack_o <= req;
            wbs.wbs_dat_o <= req ? rdata : '0;
            status <= (status & ~clr) | ch_hit;
            irq0 <= |(status & ch_irq_en);
        end
    end

    assign irq = {2'b00, irq0};
endmodule

// File: tb/tb_wb_counter_bank.sv
// tb_wb_counter_bank: directed register vectors plus counting, IRQ, LA and reset sequences.
module tb_wb_counter_bank;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] la_data_in = '0;
    logic [127:0] la_oenb = '1;
    logic [127:0] la_data_out;
    logic [37:0]  io_in = '0;
    logic [37:0]  io_out, io_oeb;
    logic [2:0]   irq;
    int           pass_cnt = 0, total_cnt = 0;

    wb_counter_bank_if wbs ();

    wb_counter_bank dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wbs(wbs),
        .la_data_in(la_data_in),
        .la_oenb(la_oenb),
        .la_data_out(la_data_out),
        .io_in(io_in),
        .io_out(io_out),
        .io_oeb(io_oeb),
        .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  off;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wb_xfer(input logic now, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] r, output logic ok);
        if (!now) @(negedge clk);
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_we_i = we;
        wbs.wbs_adr_i = a;
        wbs.wbs_dat_i = d;
        wbs.wbs_sel_i = s;
        ok = 1'b0;
        r = '0;
        for (int i = 0; i < 4 && !ok; i++) begin
            @(negedge clk);
            if (wbs.wbs_ack_o) begin
                ok = 1'b1;
                r = wbs.wbs_dat_o;
            end
        end
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i = 1'b0;
    endtask

    task automatic wb_write(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] r;
        logic ok;
        wb_xfer(1'b0, 1'b1, 32'h3000_0000 | 32'(off), d, 4'hF, r, ok);
        chk("write_ack", 64'(ok), 64'd1);
    endtask

    task automatic wb_read(input logic [7:0] off, output logic [31:0] r);
        logic ok;
        wb_xfer(1'b0, 1'b0, 32'h3000_0000 | 32'(off), 32'd0, 4'hF, r, ok);
        chk("read_ack", 64'(ok), 64'd1);
    endtask

    initial begin
        vec_t        vecs[11];
        logic [31:0] r, v;
        logic        ok, found;
        logic [31:0] exp_cnt[5];
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i = 1'b0;
        wbs.wbs_sel_i = '0;
        wbs.wbs_adr_i = '0;
        wbs.wbs_dat_i = '0;
        vecs[0]  = '{1'b0, 8'hF4, 32'h0, 4'hF, 32'h0104_2000};
        vecs[1]  = '{1'b1, 8'h28, 32'hAABB_CCDD, 4'b0010, 32'h0000_CC00};
        vecs[2]  = '{1'b1, 8'h34, 32'h1234_5678, 4'hF, 32'h1234_5678};
        vecs[3]  = '{1'b1, 8'h18, 32'hAABB_CCDD, 4'b1001, 32'hAA00_00DD};
        vecs[4]  = '{1'b1, 8'hF4, 32'hFFFF_FFFF, 4'hF, 32'h0104_2000};
        vecs[5]  = '{1'b1, 8'hF8, 32'h1234_5678, 4'hF, 32'h0};
        vecs[6]  = '{1'b1, 8'h24, 32'hFFFF_FFFF, 4'h0, 32'h0};
        vecs[7]  = '{1'b1, 8'h20, 32'hFFFF_FFF6, 4'hF, 32'h0000_0006};
        vecs[8]  = '{1'b1, 8'h3C, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b1, 8'h44, 32'h0000_0055, 4'hF, 32'h0};
        vecs[10] = '{1'b1, 8'hF0, 32'h0000_000F, 4'hF, 32'h0};

        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(wbs.wbs_ack_o), 64'd0);
        chk("rst_dat", 64'(wbs.wbs_dat_o), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_io_out", 64'(io_out), 64'd0);
        chk("rst_io_oeb", 64'(io_oeb), 64'h3F_FFFF_F0FF);
        chk("rst_la", 64'(|la_data_out), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].we) begin
                wb_xfer(1'b0, 1'b1, 32'h3000_0000 | 32'(vecs[i].off), vecs[i].wdata,
                        vecs[i].sel, r, ok);
                chk("vec_write_ack", 64'(ok), 64'd1);
            end
            wb_read(vecs[i].off, r);
            chk($sformatf("vec%0d_read", i), 64'(r), 64'(vecs[i].exp));
        end
        chk("dat_idle", 64'(wbs.wbs_dat_o), 64'd0);

        wb_write(8'h04, 32'd5);
        wb_write(8'h08, 32'd8);
        wb_write(8'h00, 32'h0D);
        wb_write(8'h0C, 32'd5);
        chk("ch0_v0", 64'(la_data_out[31:0]), 64'd5);
        exp_cnt = '{32'd6, 32'd7, 32'd8, 32'd5, 32'd6};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("ch0_count%0d", k), 64'(la_data_out[31:0]), 64'(exp_cnt[k]));
            if (k == 3) begin
                chk("ch0_irq_lag", 64'(irq), 64'd0);
                chk("ch0_tog", 64'(io_out[8]), 64'd1);
            end
            if (k == 4) chk("ch0_irq", 64'(irq), 64'd1);
        end

        wb_write(8'h18, 32'hFFFF_FFFF);
        wb_write(8'h1C, 32'd1);
        wb_write(8'h10, 32'h03);
        chk("ch1_v0", 64'(la_data_out[63:32]), 64'd1);
        exp_cnt = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("ch1_count%0d", k), 64'(la_data_out[63:32]), 64'(exp_cnt[k]));
        end
        chk("ch1_tog", 64'(io_out[9]), 64'd1);
        wb_read(8'hF0, r);
        chk("status_both", 64'(r), 64'h3);

        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (la_data_out[31:0] == 32'd8) found = 1'b1;
        end
        chk("sync_wait", 64'(found), 64'd1);
        wb_xfer(1'b1, 1'b1, 32'h3000_00F0, 32'h1, 4'hF, r, ok);
        chk("sync_clr_ack", 64'(ok), 64'd1);
        wb_read(8'hF0, r);
        chk("set_wins", 64'(r), 64'h3);

        wb_write(8'h00, 32'h08);
        wb_write(8'hF0, 32'h1);
        chk("irq_hold", 64'(irq), 64'd1);
        @(negedge clk);
        chk("irq_fall", 64'(irq), 64'd0);
        wb_read(8'hF0, r);
        chk("status_clr", 64'(r), 64'h2);

        wb_write(8'h0C, 32'h100);
        @(negedge clk);
        la_oenb[127] = 1'b0;
        la_data_in[127] = 1'b1;
        v = la_data_out[31:0];
        chk("la_v0", 64'(v), 64'h100);
        @(negedge clk);
        chk("la_v1", 64'(la_data_out[31:0]), 64'h101);
        @(negedge clk);
        chk("la_v2", 64'(la_data_out[31:0]), 64'h102);
        la_oenb[127] = 1'b1;
        @(negedge clk);
        chk("la_stop", 64'(la_data_out[31:0]), 64'h102);

        wb_xfer(1'b0, 1'b1, 32'h3000_0104, 32'hF, 4'hF, r, ok);
        chk("no_ack", 64'(ok), 64'd0);
        wb_read(8'h04, r);
        chk("no_side_effect", 64'(r), 64'd5);

        @(negedge clk);
        rst = 1'b1;
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_we_i = 1'b1;
        wbs.wbs_adr_i = 32'h3000_0034;
        wbs.wbs_dat_i = 32'hCAFE_F00D;
        wbs.wbs_sel_i = 4'hF;
        @(negedge clk);
        chk("rst_mid_ack", 64'(wbs.wbs_ack_o), 64'd0);
        chk("rst_mid_la", 64'(|la_data_out), 64'd0);
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i = 1'b0;
        rst = 1'b0;
        wb_read(8'h34, r);
        chk("rst_write_dropped", 64'(r), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
